nios2_mul_seq_cell: RTL and testbench
=====================================

// Module: nios2_mul_seq_cell
// PURPOSE
//  Parametrised iterative multiplier for the Nios II execute/memory stage. It
//  replaces fixed 16x16 partial-product cells with one PART_W x PART_W DSP
//  multiplier that is time-shared over NPART*NPART cycles (NPART = DATA_W/PART_W).
//  It returns the low or high half of the 2*DATA_W product, in signed, unsigned
//  or mixed mode, over a valid/ready handshake.
// PARAMETERS
//  DATA_W  32  operand and result width; must be an integer multiple of PART_W
//  PART_W  16  width of each partial-product slice (the native DSP width)
// PORTS
//  clk        in   1       clock; all state changes on the rising edge
//  reset_n    in   1       synchronous reset, active-low
//  in_valid   in   1       operands and mode are valid this cycle
//  in_ready   out  1       block can accept an operation (state IDLE)
//  in_src1    in   DATA_W  operand A
//  in_src2    in   DATA_W  operand B
//  in_mode    in   2       00 MUL (low half), 01 MULXSS, 10 MULXSU, 11 MULXUU (high half)
//  flush      in   1       abort the operation in flight
//  out_valid  out  1       out_result holds a completed result
//  out_ready  in   1       consumer takes the result
//  out_result out  DATA_W  selected product half
//  busy       out  1       high in states MULT and FIX
// BEHAVIOUR
//  Reset (reset_n=0 at an edge):
//   - state=IDLE; out_valid=0, out_result=0, busy=0, in_ready=1.
//   - Accumulator, counter and latched operands cleared.
//   - Reset takes priority over every other input, including mid-operation.
//  FSM (IDLE, MULT, FIX, DONE):
//   - IDLE -> MULT on in_valid&in_ready. Latch |A| and |B|, the result sign,
//     and the mode. An operand is treated as signed when: MULXSS, both
//     operands; MULXSU, A only; MUL, MULXUU, neither. Clear acc (2*DATA_W)
//     and cnt.
//   - MULT: one slice product per cycle:
//     acc += (a[i]*b[j]) << PART_W*(i+j), with i=cnt%NPART, j=cnt/NPART.
//     After cnt=NPART*NPART-1 the next state is FIX.
//   - FIX: acc = sign ? -acc : acc (two's complement over 2*DATA_W).
//     out_result = mode==00 ? acc[DATA_W-1:0] : acc[2*DATA_W-1:DATA_W].
//     Set out_valid=1, then go to DONE.
//   - DONE: hold out_valid and out_result stable until out_ready=1, then go
//     to IDLE with out_valid=0. in_ready stays 0 in DONE; there is no
//     same-cycle accept.
//  Latency:
//   - out_valid is 1 after NPART*NPART+1 edges following the accept edge
//     (5 at the defaults).
//   - Throughput is 1 operation per NPART*NPART+2 cycles when out_ready is
//     tied high.
//  Flush:
//   - In MULT, FIX or DONE, flush=1 forces IDLE at the next edge with
//     out_valid=0.
//   - The result is discarded and out_result keeps its last value.
//   - If flush and out_ready are both 1 in DONE, flush wins; the effect is the
//     same, with no extra pulse.
//   - flush is ignored in IDLE, and in_valid is not accepted while flush=1.
//  Arithmetic:
//   - Slice products are PART_W x PART_W unsigned -> 2*PART_W.
//   - The accumulator adds never overflow 2*DATA_W.
//   - The -2^(DATA_W-1) magnitude is handled as an unsigned 2^(DATA_W-1).
//  in_src*/in_mode changes after accept have no effect on the operation in
//  flight.
// TESTING
//  A=0xFFFFFFFF, B=0xFFFFFFFF:
//   - MUL -> 0x00000001.
//   - MULXUU -> 0xFFFFFFFE.
//   - MULXSS -> 0x00000000.
//   - MULXSU -> 0xFFFFFFFF.
//  A=0x80000000, B=0x00000002:
//   - MULXSS -> 0xFFFFFFFF.
//   - MUL -> 0x00000000.
//   - MULXUU -> 0x00000001.
//  Accept at edge T0 with out_ready=1: out_valid rises after T5, drops after
//  T6, and in_ready=1 at T6.
//  Hold out_ready=0 for 10 cycles in DONE: out_valid and out_result stay
//  stable, and in_valid is ignored (in_ready=0).
//  Assert flush during MULT cnt=2: IDLE next cycle with no out_valid. The
//  next op, 7*6 MUL, returns 0x0000002A.
//  Assert reset_n=0 in FIX: all outputs return to reset values at the next
//  edge. Repeat the checks with DATA_W=48, PART_W=16 using random signed
//  vectors against a reference model.

Source files
------------

// File: rtl/nios2_mul_seq_cell.sv
// Iterative multiplier: one PART_W x PART_W slice product per cycle,
// sign fix-up at the end, low or high half returned over valid/ready.
module nios2_mul_seq_cell #(
  parameter int DATA_W = 32,
  parameter int PART_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              busy
);
  localparam int NPART = DATA_W / PART_W;
  localparam int ACC_W = 2 * DATA_W;
  localparam int IDX_W = (NPART > 1) ? $clog2(NPART) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_FIX, S_DONE} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                neg_r, hi_r;
  logic [IDX_W-1:0]    i_idx, j_idx;
  logic [ACC_W-1:0]    acc;

  logic                a_sgn, b_sgn, a_neg, b_neg, accept, last;
  logic [PART_W-1:0]   a_sl, b_sl;
  logic [2*PART_W-1:0] prod;
  logic [ACC_W-1:0]    pp, acc_fix;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_MULT) || (state == S_FIX);

  // Operand signedness, slice selection, partial product and sign fix-up
  always_comb begin
    a_sgn   = (in_mode == 2'b01) || (in_mode == 2'b10);
    b_sgn   = (in_mode == 2'b01);
    a_neg   = a_sgn & in_src1[DATA_W-1];
    b_neg   = b_sgn & in_src2[DATA_W-1];
    accept  = in_valid & in_ready & ~flush;
    last    = (i_idx == IDX_W'(NPART-1)) && (j_idx == IDX_W'(NPART-1));
    a_sl    = PART_W'(a_mag >> (PART_W * int'(i_idx)));
    b_sl    = PART_W'(b_mag >> (PART_W * int'(j_idx)));
    prod    = {{PART_W{1'b0}}, a_sl} * {{PART_W{1'b0}}, b_sl};
    pp      = ACC_W'(prod) << (PART_W * (int'(i_idx) + int'(j_idx)));
    acc_fix = neg_r ? -acc : acc;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state; flush aborts any non-idle state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_MULT;
      S_MULT: if (flush) state_nx = S_IDLE;
              else if (last) state_nx = S_FIX;
      S_FIX:  state_nx = flush ? S_IDLE : S_DONE;
      S_DONE: if (flush || out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: latch magnitudes on accept, accumulate slices, fix sign, present result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_mag      <= '0;
      b_mag      <= '0;
      neg_r      <= 1'b0;
      hi_r       <= 1'b0;
      i_idx      <= '0;
      j_idx      <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          // -2^(DATA_W-1) negates to itself, which reads correctly as unsigned
          a_mag <= a_neg ? -in_src1 : in_src1;
          b_mag <= b_neg ? -in_src2 : in_src2;
          neg_r <= a_neg ^ b_neg;
          hi_r  <= (in_mode != 2'b00);
          i_idx <= '0;
          j_idx <= '0;
          acc   <= '0;
        end
        S_MULT: if (!flush) begin
          acc <= acc + pp;
          if (i_idx == IDX_W'(NPART-1)) begin
            i_idx <= '0;
            j_idx <= j_idx + IDX_W'(1);
          end else begin
            i_idx <= i_idx + IDX_W'(1);
          end
        end
        S_FIX: if (!flush) begin
          acc        <= acc_fix;
          out_result <= hi_r ? acc_fix[ACC_W-1:DATA_W] : acc_fix[DATA_W-1:0];
          out_valid  <= 1'b1;
        end
        S_DONE: if (flush || out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nios2_mul_seq_cell.sv
// Bench for nios2_mul_seq_cell: a 32/16 and a 48/16 instance checked against
// a full-width sign-extended multiply model.
module tb_nios2_mul_seq_cell;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [1:0]       iv, ir, ov, bz, fl, ordy;
  logic [1:0][1:0]  md;
  logic [1:0][47:0] s1, s2;
  logic [31:0]      r32;
  logic [47:0]      r48;

  int errors = 0;
  int checks = 0;

  nios2_mul_seq_cell #(.DATA_W(32), .PART_W(16)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_src1(s1[0][31:0]), .in_src2(s2[0][31:0]), .in_mode(md[0]), .flush(fl[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_result(r32), .busy(bz[0]));

  nios2_mul_seq_cell #(.DATA_W(48), .PART_W(16)) u48 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_src1(s1[1]), .in_src2(s2[1]), .in_mode(md[1]), .flush(fl[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_result(r48), .busy(bz[1]));

  function automatic logic [47:0] res(input int d);
    return (d != 0) ? r48 : {16'b0, r32};
  endfunction

  // Reference: sign/zero extend to 128 bits, multiply, pick the requested half
  function automatic logic [47:0] ref_mul(input int w, input logic [47:0] a, input logic [47:0] b,
                                          input logic [1:0] m);
    logic [127:0] mask, ea, eb, p;
    mask = (128'd1 << w) - 128'd1;
    ea = {80'b0, a} & mask;
    eb = {80'b0, b} & mask;
    if ((m == 2'b01 || m == 2'b10) && a[w-1]) ea = ea | ~mask;
    if (m == 2'b01 && b[w-1]) eb = eb | ~mask;
    p = ea * eb;
    p = (m == 2'b00) ? (p & mask) : ((p >> w) & mask);
    return p[47:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on DUT d; hold>0 keeps out_ready low that many cycles in DONE
  task automatic op(input int d, input logic [47:0] a, input logic [47:0] b, input logic [1:0] m,
                    input int hold, input string tag);
    int w, lat, k;
    logic [47:0] exp, held;
    w   = (d != 0) ? 48 : 32;
    lat = (d != 0) ? 10 : 5;
    exp = ref_mul(w, a, b, m);
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(ir[d]), 64'd1);
    iv[d] = 1'b1; s1[d] = a; s2[d] = b; md[d] = m; ordy[d] = (hold == 0);
    @(negedge clk);
    iv[d] = 1'b0; s1[d] = {$urandom, $urandom}; s2[d] = {$urandom, $urandom};
    md[d] = 2'($urandom);
    chk({tag, " busy"}, 64'(bz[d]), 64'd1);
    k = 0;
    while (!ov[d] && k < 40) begin @(negedge clk); k++; end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " result"}, 64'(res(d)), 64'(exp));
    held = res(d);
    for (int c = 0; c < hold; c++) begin
      iv[d] = 1'b1;
      @(negedge clk);
      chk({tag, " hold"}, {14'b0, ov[d], ir[d], res(d)}, {14'b0, 1'b1, 1'b0, held});
    end
    iv[d] = 1'b0; ordy[d] = 1'b1;
    @(negedge clk);
    chk({tag, " release"}, {62'b0, ov[d], ir[d]}, 64'b01);
  endtask

  initial begin
    logic [47:0] held, a, b, corner;
    logic [1:0]  m;
    int k;
    reset_n = 1'b0; iv = '0; fl = '0; ordy = 2'b11; md = '0; s1 = '0; s2 = '0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", 64'(ov), 64'd0);
    chk("rst busy", 64'(bz), 64'd0);
    chk("rst in_ready", 64'(ir), 64'd3);
    chk("rst result32", 64'(r32), 64'd0);
    chk("rst result48", 64'(r48), 64'd0);
    reset_n = 1'b1;

    op(0, 48'hFFFFFFFF, 48'hFFFFFFFF, 2'b00, 0, "ff MUL");
    chk("ff MUL const", 64'(r32), 64'h00000001);
    op(0, 48'hFFFFFFFF, 48'hFFFFFFFF, 2'b11, 0, "ff MULXUU");
    chk("ff MULXUU const", 64'(r32), 64'hFFFFFFFE);
    op(0, 48'hFFFFFFFF, 48'hFFFFFFFF, 2'b01, 0, "ff MULXSS");
    chk("ff MULXSS const", 64'(r32), 64'h00000000);
    op(0, 48'hFFFFFFFF, 48'hFFFFFFFF, 2'b10, 0, "ff MULXSU");
    chk("ff MULXSU const", 64'(r32), 64'hFFFFFFFF);
    op(0, 48'h80000000, 48'h2, 2'b01, 0, "min MULXSS");
    chk("min MULXSS const", 64'(r32), 64'hFFFFFFFF);
    op(0, 48'h80000000, 48'h2, 2'b00, 0, "min MUL");
    op(0, 48'h80000000, 48'h2, 2'b11, 0, "min MULXUU");
    chk("min MULXUU const", 64'(r32), 64'h00000001);

    op(0, 48'h12345678, 48'h9ABCDEF0, 2'b10, 10, "hold");

    // flush while the accumulator is at slice 2
    held = res(0);
    @(negedge clk);
    iv[0] = 1'b1; s1[0] = 48'd5; s2[0] = 48'd9; md[0] = 2'b00;
    @(negedge clk); iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    chk("flush mult state", {61'b0, ov[0], bz[0], ir[0]}, 64'b001);
    chk("flush keeps result", 64'(r32), 64'(held));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flush no valid", 64'(ov[0]), 64'd0);
    end
    op(0, 48'd7, 48'd6, 2'b00, 0, "after flush");
    chk("after flush const", 64'(r32), 64'h2A);

    // flush and out_ready together in DONE
    @(negedge clk);
    iv[0] = 1'b1; s1[0] = 48'd11; s2[0] = 48'd13; md[0] = 2'b00; ordy[0] = 1'b0;
    @(negedge clk); iv[0] = 1'b0;
    k = 0;
    while (!ov[0] && k < 40) begin @(negedge clk); k++; end
    chk("done flush valid seen", 64'(ov[0]), 64'd1);
    fl[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    chk("done flush idle", {62'b0, ov[0], ir[0]}, 64'b01);
    chk("done flush result", 64'(r32), 64'd143);
    repeat (2) begin
      @(negedge clk);
      chk("done flush no pulse", 64'(ov[0]), 64'd0);
    end

    // in_valid ignored while flush is high in IDLE
    fl[0] = 1'b1; iv[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle flush no accept", {62'b0, bz[0], ir[0]}, 64'b01);
    fl[0] = 1'b0; iv[0] = 1'b0;

    // reset while in FIX
    @(negedge clk);
    iv[0] = 1'b1; s1[0] = 48'd3; s2[0] = 48'd4; md[0] = 2'b00;
    @(negedge clk); iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("fix busy", {62'b0, ov[0], bz[0]}, 64'b01);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("fix reset flags", {61'b0, ov[0], bz[0], ir[0]}, 64'b001);
    chk("fix reset result", 64'(r32), 64'd0);

    op(1, 48'h800000000000, 48'h2, 2'b01, 0, "w48 min MULXSS");
    op(1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 2'b11, 0, "w48 ff MULXUU");

    for (int n = 0; n < 60; n++) begin
      int d;
      d = (n < 30) ? 0 : 1;
      corner = (d != 0) ? 48'h800000000000 : 48'h80000000;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) a = corner;
      if ($urandom_range(0, 5) == 0) b = corner;
      if (d == 0) begin a = a & 48'hFFFFFFFF; b = b & 48'hFFFFFFFF; end
      m = 2'($urandom);
      op(d, a, b, m, 0, (d != 0) ? "rand48" : "rand32");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
